serial_xfer: RTL
================

Name: serial_xfer

Overview:
- Parametrised successor to the single-byte UART send/receive helper.
- Runs one command per transaction: transmits 0..MAX_TX bytes to the UART TX core, then collects 0..MAX_RX reply bytes from the UART RX core.
- Reports the reply with a byte count and a timeout flag.
- Sits between a register/host controller and the UART TX/RX cores.

Parameters:
- MAX_TX, 4, maximum bytes sent per command (1..16).
- MAX_RX, 4, maximum bytes received per command (1..16).
- TIMEOUT, 1000000, clk cycles allowed between received bytes; must be >= 2.
- TXL_W, $clog2(MAX_TX+1), width of cmd_tx_len (derived).
- RXL_W, $clog2(MAX_RX+1), width of cmd_rx_len and rsp_rx_count (derived).

Ports:
- clk, in, 1: clock.
- reset, in, 1: reset, synchronous, active-high.
- cmd_valid, in, 1: start request; accepted when cmd_ready=1.
- cmd_ready, out, 1: high only in IDLE.
- cmd_tx_len, in, TXL_W: bytes to send; values > MAX_TX clamp to MAX_TX.
- cmd_rx_len, in, RXL_W: bytes expected; values > MAX_RX clamp to MAX_RX.
- cmd_tx_data, in, 8*MAX_TX: byte i at [8i+7:8i]; byte 0 sent first.
- rsp_valid, out, 1: one-cycle pulse at command end.
- rsp_rx_data, out, 8*MAX_RX: byte i at [8i+7:8i]; slots not received read 0.
- rsp_rx_count, out, RXL_W: bytes actually received.
- rsp_timeout, out, 1: valid with rsp_valid; 1 if the RX phase timed out.
- tx_data, out, 8: byte to the UART TX core.
- tx_wr_strobe, out, 1: one-cycle write pulse.
- tx_busy, in, 1: UART TX core busy.
- rx_data, in, 8: UART RX byte.
- rx_valid, in, 1: UART RX byte available.
- rx_rd_strobe, out, 1: one-cycle acknowledge/pop.

Behaviour:
- Reset: cmd_ready=0 during reset, 1 on the first cycle after. All other outputs 0. State=IDLE; counters and data registers cleared.
- Reset asserted mid-transaction aborts immediately: no rsp_valid and no further strobes.
- States: IDLE, TX_WAIT, TX_GAP, RX_WAIT, RX_ACK, DONE. Unknown state encodings go to IDLE.
- IDLE:
  - On cmd_valid, latch the clamped lengths and cmd_tx_data, clear rsp_rx_data, rsp_rx_count and the timer.
  - Next state: TX_WAIT if tx_len>0; else RX_WAIT if rx_len>0; else DONE.
- TX_WAIT: when tx_busy=0, drive tx_data=byte[tx_idx], pulse tx_wr_strobe for 1 cycle, increment tx_idx, go to TX_GAP.
- TX_GAP: 1 cycle with tx_busy ignored, covering busy-assert latency. Then go to TX_WAIT if bytes remain, else to RX_WAIT (rx_len>0) or DONE.
- RX_WAIT:
  - Timer increments each cycle.
  - On rx_valid: store rx_data at slot rsp_rx_count, increment rsp_rx_count, pulse rx_rd_strobe for 1 cycle, clear the timer, go to RX_ACK.
  - When the timer reaches TIMEOUT-1 with rx_valid=0: set the timeout flag, go to DONE.
  - If rx_valid is high on the expiry cycle, the byte wins and no timeout is flagged.
- RX_ACK: 1 cycle with rx_valid ignored, letting the RX core drop valid. Then go to RX_WAIT if rsp_rx_count<rx_len, else DONE.
- DONE: pulse rsp_valid for 1 cycle with rsp_timeout, go to IDLE. rsp_rx_data and rsp_rx_count hold until the next command is accepted.
- Latency:
  - tx_len=0 and rx_len=0: rsp_valid 2 cycles after acceptance.
  - Each TX byte takes at least 2 cycles; each RX byte at least 2 cycles.
- rx_valid during IDLE or TX states is not consumed unless the flush feature is enabled.
- cmd_valid outside IDLE is ignored.

Optional Feature:
- Macro SERIAL_XFER_FLUSH_EN.
- Defined: on command acceptance, enter an extra FLUSH state before TX. While rx_valid=1, pulse rx_rd_strobe every other cycle and discard the byte. Leave FLUSH on the first cycle rx_valid=0 after a non-strobe cycle. Stale bytes never appear in rsp_rx_data.
- Undefined: FLUSH state absent. Stale bytes pending at command start are received as reply byte 0.

Test Plan:
- tx_len=2, data 0x4241, rx_len=1, tx_busy held 3 cycles after each strobe, RX returns 0x55 -> tx_data 0x41 then 0x42, exactly 2 tx_wr_strobe pulses; rsp_rx_data[7:0]=0x55, count=1, timeout=0, one rx_rd_strobe.
- tx_len=0, rx_len=3, RX supplies 0x01,0x02,0x03 -> no tx_wr_strobe; rsp_rx_data[23:0]=0x030201, count=3.
- TIMEOUT=20, tx_len=1, rx_len=2, only one byte 0xAA arrives -> rsp_valid 20 cycles after the rx_rd_strobe, count=1, timeout=1, slot 1 reads 0x00.
- tx_len=0, rx_len=0 -> rsp_valid exactly 2 cycles after acceptance, count=0; cmd_tx_len=7 with MAX_TX=4 -> exactly 4 bytes sent.
- Reset pulsed during the second TX byte -> no further strobes, no rsp_valid, cmd_ready=1 on the first cycle after reset deasserts, all outputs 0.
- With SERIAL_XFER_FLUSH_EN, stale 0x99 pending at command start -> discarded via rx_rd_strobe before the first tx_wr_strobe; reply 0x10 reported as byte 0.

Source files
------------

// File: rtl/serial_xfer.sv
`default_nettype none
// ============================================================================
// Module   : serial_xfer
// Brief    : One command per transaction: send 0..MAX_TX bytes to a UART TX
//            core, then collect 0..MAX_RX reply bytes from a UART RX core.
//            Optional macro SERIAL_XFER_FLUSH_EN discards stale RX bytes
//            before the TX phase.
// Revision : 1.0 - initial release
// ============================================================================
module serial_xfer #(
    parameter int MAX_TX  = 4,
    parameter int MAX_RX  = 4,
    parameter int TIMEOUT = 1000000,
    parameter int TXL_W   = $clog2(MAX_TX + 1),
    parameter int RXL_W   = $clog2(MAX_RX + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [TXL_W-1:0]    cmd_tx_len,
    input  logic [RXL_W-1:0]    cmd_rx_len,
    input  logic [8*MAX_TX-1:0] cmd_tx_data,
    output logic                rsp_valid,
    output logic [8*MAX_RX-1:0] rsp_rx_data,
    output logic [RXL_W-1:0]    rsp_rx_count,
    output logic                rsp_timeout,
    output logic [7:0]          tx_data,
    output logic                tx_wr_strobe,
    input  logic                tx_busy,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_rd_strobe
);

    localparam int               TMR_W        = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] c_timer_last = TMR_W'(TIMEOUT - 1);
    localparam logic [TXL_W-1:0] c_max_tx     = TXL_W'(MAX_TX);
    localparam logic [RXL_W-1:0] c_max_rx     = RXL_W'(MAX_RX);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TX_WAIT = 3'd1,
        TX_GAP  = 3'd2,
        RX_WAIT = 3'd3,
        RX_ACK  = 3'd4,
`ifdef SERIAL_XFER_FLUSH_EN
        DONE    = 3'd5,
        FLUSH   = 3'd6
`else
        DONE    = 3'd5
`endif
    } state_t;

    state_t              r_state;
    logic [TXL_W-1:0]    r_tx_len;
    logic [RXL_W-1:0]    r_rx_len;
    logic [TXL_W-1:0]    r_tx_idx;
    logic [8*MAX_TX-1:0] r_tx_buf;
    logic [TMR_W-1:0]    r_timer;
    logic                r_timed_out;

    logic [TXL_W-1:0]    w_tx_len;
    logic [RXL_W-1:0]    w_rx_len;
    logic [TMR_W-1:0]    w_timer_next;

    assign w_tx_len     = (cmd_tx_len > c_max_tx) ? c_max_tx : cmd_tx_len;
    assign w_rx_len     = (cmd_rx_len > c_max_rx) ? c_max_rx : cmd_rx_len;
    assign w_timer_next = r_timer + TMR_W'(1);

    // Combinational so the port reads 1 on the very first cycle out of reset.
    assign cmd_ready = (r_state == IDLE) && !reset;

    function automatic state_t after_tx(input logic [RXL_W-1:0] rx_len);
        return (rx_len != '0) ? RX_WAIT : DONE;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_tx_len     <= '0;
            r_rx_len     <= '0;
            r_tx_idx     <= '0;
            r_tx_buf     <= '0;
            r_timer      <= '0;
            r_timed_out  <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rx_data  <= '0;
            rsp_rx_count <= '0;
            rsp_timeout  <= 1'b0;
            tx_data      <= '0;
            tx_wr_strobe <= 1'b0;
            rx_rd_strobe <= 1'b0;
        end else begin
            tx_wr_strobe <= 1'b0;
            rx_rd_strobe <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_timeout  <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_tx_len     <= w_tx_len;
                        r_rx_len     <= w_rx_len;
                        r_tx_buf     <= cmd_tx_data;
                        r_tx_idx     <= '0;
                        rsp_rx_data  <= '0;
                        rsp_rx_count <= '0;
                        r_timer      <= '0;
                        r_timed_out  <= 1'b0;
`ifdef SERIAL_XFER_FLUSH_EN
                        r_state      <= FLUSH;
`else
                        r_state      <= (w_tx_len != '0) ? TX_WAIT : after_tx(w_rx_len);
`endif
                    end
                end

`ifdef SERIAL_XFER_FLUSH_EN
                // A strobe cycle is always followed by one ignored cycle so the
                // RX core has time to drop or refresh rx_valid.
                FLUSH: begin
                    if (!rx_rd_strobe) begin
                        if (rx_valid) begin
                            rx_rd_strobe <= 1'b1;
                        end else begin
                            r_state <= (r_tx_len != '0) ? TX_WAIT : after_tx(r_rx_len);
                        end
                    end
                end
`endif

                TX_WAIT: begin
                    if (!tx_busy) begin
                        tx_data      <= r_tx_buf[7:0];
                        r_tx_buf     <= r_tx_buf >> 8;
                        tx_wr_strobe <= 1'b1;
                        r_tx_idx     <= r_tx_idx + TXL_W'(1);
                        r_state      <= TX_GAP;
                    end
                end

                TX_GAP: begin
                    r_state <= (r_tx_idx < r_tx_len) ? TX_WAIT : after_tx(r_rx_len);
                end

                RX_WAIT: begin
                    if (rx_valid) begin
                        for (int i = 0; i < MAX_RX; i++) begin
                            if (rsp_rx_count == RXL_W'(i)) begin
                                rsp_rx_data[8*i +: 8] <= rx_data;
                            end
                        end
                        rsp_rx_count <= rsp_rx_count + RXL_W'(1);
                        rx_rd_strobe <= 1'b1;
                        r_timer      <= '0;
                        r_state      <= RX_ACK;
                    end else if (w_timer_next >= c_timer_last) begin
                        // Expiring one count early lands the registered
                        // rsp_valid TIMEOUT cycles after the last strobe.
                        r_timed_out <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_timer <= w_timer_next;
                    end
                end

                RX_ACK: begin
                    r_timer <= w_timer_next;
                    r_state <= (rsp_rx_count < r_rx_len) ? RX_WAIT : DONE;
                end

                DONE: begin
                    rsp_valid   <= 1'b1;
                    rsp_timeout <= r_timed_out;
                    r_state     <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
